// File: rtl/mem_sm_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_sm_mem_pkg
// Brief    : Default geometry and elaboration checks for the state-machine memory.
// Revision : 1.0
// ============================================================================
package mem_sm_mem_pkg;

    localparam int NUMRPRT_DEF = 2;
    localparam int NUMWPRT_DEF = 1;
    localparam int NUMADDR_DEF = 1024;
    localparam int BITDATA_DEF = 45;
    localparam int BITADDR_DEF = 10;
    localparam int FLOPOUT_DEF = 0;

    // True when an address bus of width bitaddr can reach every word.
    function automatic bit addr_fits(input int bitaddr, input int numaddr);
        return bitaddr >= $clog2(numaddr);
    endfunction

    localparam bit ADDR_CHECK_DEF = addr_fits(BITADDR_DEF, NUMADDR_DEF);

endpackage : mem_sm_mem_pkg
`default_nettype wire

// File: rtl/mem_sm_mem_rd_port.sv
`default_nettype none
// ============================================================================
// Module   : mem_sm_mem_rd_port
// Brief    : One read register with hold-on-idle plus optional output stage.
// Revision : 1.0
// ============================================================================
module mem_sm_mem_rd_port #(
    parameter int BITDATA = 45,
    parameter int FLOPOUT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_en_i,
    input  logic [BITDATA-1:0] rd_data_i,
    output logic [BITDATA-1:0] rd_dout_o
);

    logic [BITDATA-1:0] rd_d;
    logic [BITDATA-1:0] rd_q;

    always_comb begin
        rd_d = rd_q;
        if (rd_en_i) begin
            rd_d = rd_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    generate
        if (FLOPOUT != 0) begin : g_flopout
            logic [BITDATA-1:0] out_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_q <= '0;
                end else begin
                    out_q <= rd_q;
                end
            end

            assign rd_dout_o = out_q;
        end else begin : g_direct
            assign rd_dout_o = rd_q;
        end
    endgenerate

endmodule : mem_sm_mem_rd_port
`default_nettype wire

// File: rtl/mem_sm_mem.sv
`default_nettype none
// ============================================================================
// Module   : mem_sm_mem
// Brief    : Multi-port synchronous memory, read-before-write, highest write
//            port wins on address collision, out-of-range reads return zero.
// Revision : 1.0
// ============================================================================
module mem_sm_mem
    import mem_sm_mem_pkg::*;
#(
    parameter int NUMRPRT = NUMRPRT_DEF,
    parameter int NUMWPRT = NUMWPRT_DEF,
    parameter int NUMADDR = NUMADDR_DEF,
    parameter int BITDATA = BITDATA_DEF,
    parameter int BITADDR = BITADDR_DEF,
    parameter int FLOPOUT = FLOPOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUMWPRT-1:0] sm_mem_write,
    input  logic [BITADDR-1:0] sm_mem_wr_adr  [0:NUMWPRT-1],
    input  logic [BITDATA-1:0] sm_mem_din     [0:NUMWPRT-1],
    input  logic [NUMRPRT-1:0] sm_mem_read,
    input  logic [BITADDR-1:0] sm_mem_rd_adr  [0:NUMRPRT-1],
    output logic [BITDATA-1:0] sm_mem_rd_dout [0:NUMRPRT-1]
);

    localparam bit               ADDR_OK    = addr_fits(BITADDR, NUMADDR);
    localparam logic [BITADDR:0] ADDR_LIMIT = (BITADDR+1)'(NUMADDR);

    generate
        if (!ADDR_OK) begin : g_addr_check
            $error("mem_sm_mem: BITADDR too narrow for NUMADDR");
        end
        if ((FLOPOUT != 0) && (FLOPOUT != 1)) begin : g_flopout_check
            $error("mem_sm_mem: FLOPOUT must be 0 or 1");
        end
    endgenerate

    logic [BITDATA-1:0] mem_q [0:NUMADDR-1];
    logic               run_d;
    logic               run_q;
    logic [NUMWPRT-1:0] wr_ok;
    logic [BITDATA-1:0] rd_data [0:NUMRPRT-1];

    // Write gate derived from a flop so the storage never samples the async reset.
    assign run_d = 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run_d;
        end
    end

    always_comb begin
        wr_ok = '0;
        for (int i = 0; i < NUMWPRT; i++) begin
            wr_ok[i] = run_q && rst && sm_mem_write[i]
                       && ({1'b0, sm_mem_wr_adr[i]} < ADDR_LIMIT);
        end
    end

    // Ascending loop: the last enabled port in index order lands in storage.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUMWPRT; i++) begin
            if (wr_ok[i]) begin
                mem_q[sm_mem_wr_adr[i]] <= sm_mem_din[i];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUMRPRT; j++) begin
            rd_data[j] = '0;
            if ({1'b0, sm_mem_rd_adr[j]} < ADDR_LIMIT) begin
                rd_data[j] = mem_q[sm_mem_rd_adr[j]];
            end
        end
    end

    generate
        for (genvar j = 0; j < NUMRPRT; j++) begin : g_rd_port
            mem_sm_mem_rd_port #(
                .BITDATA (BITDATA),
                .FLOPOUT (FLOPOUT)
            ) u_rd_port (
                .clk       (clk),
                .rst_n     (rst),
                .rd_en_i   (sm_mem_read[j]),
                .rd_data_i (rd_data[j]),
                .rd_dout_o (sm_mem_rd_dout[j])
            );
        end
    endgenerate

endmodule : mem_sm_mem
`default_nettype wire

// File: tb/tb_mem_sm_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_sm_mem
// Brief    : Self-checking bench with a word-level reference memory model.
// Revision : 1.0
// ============================================================================
module tb_mem_sm_mem;

    localparam int NR = 2;
    localparam int NW = 2;
    localparam int NA = 1000;
    localparam int BD = 45;
    localparam int BA = 10;
    localparam int FO = 0;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NW-1:0] wr_en = '0;
    logic [BA-1:0] wr_adr [0:NW-1];
    logic [BD-1:0] din    [0:NW-1];
    logic [NR-1:0] rd_en = '0;
    logic [BA-1:0] rd_adr [0:NR-1];
    logic [BD-1:0] dout   [0:NR-1];

    int checks = 0;
    int passes = 0;

    // Reference model: word array with a written-flag per word, plus per-port expected output.
    logic [BD-1:0] m_mem   [0:1023];
    bit            m_valid [0:1023];
    logic [BD-1:0] e_s1  [0:NR-1];
    logic [BD-1:0] e_out [0:NR-1];
    bit            k_s1  [0:NR-1];
    bit            k_out [0:NR-1];

    mem_sm_mem #(
        .NUMRPRT (NR), .NUMWPRT (NW), .NUMADDR (NA),
        .BITDATA (BD), .BITADDR (BA), .FLOPOUT (FO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sm_mem_write   (wr_en),
        .sm_mem_wr_adr  (wr_adr),
        .sm_mem_din     (din),
        .sm_mem_read    (rd_en),
        .sm_mem_rd_adr  (rd_adr),
        .sm_mem_rd_dout (dout)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic [BD-1:0] rv;
        bit            rk;
        if (!rst) begin
            for (int p = 0; p < NR; p++) begin
                e_s1[p] = '0; e_out[p] = '0; k_s1[p] = 1'b1; k_out[p] = 1'b1;
            end
        end else begin
            for (int p = 0; p < NR; p++) begin
                if (FO != 0) begin
                    e_out[p] = e_s1[p]; k_out[p] = k_s1[p];
                end
                if (rd_en[p]) begin
                    if (int'(rd_adr[p]) >= NA) begin
                        rv = '0; rk = 1'b1;
                    end else begin
                        rv = m_mem[rd_adr[p]]; rk = m_valid[rd_adr[p]];
                    end
                    e_s1[p] = rv; k_s1[p] = rk;
                end
                if (FO == 0) begin
                    e_out[p] = e_s1[p]; k_out[p] = k_s1[p];
                end
            end
            for (int w = 0; w < NW; w++) begin
                if (wr_en[w] && int'(wr_adr[w]) < NA) begin
                    m_mem[wr_adr[w]] = din[w];
                    m_valid[wr_adr[w]] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) m_valid[a] = 1'b0;
        for (int p = 0; p < NR; p++) begin
            k_s1[p] = 1'b0; k_out[p] = 1'b0; e_s1[p] = '0; e_out[p] = '0;
        end
        forever begin
            @(posedge clk or negedge rst);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int p = 0; p < NR; p++) begin
                if (k_out[p]) begin
                    checks++;
                    if (dout[p] === e_out[p]) passes++;
                    else $display("FAIL model_dout%0d t=%0t got=%h exp=%h", p, $time, dout[p], e_out[p]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [BD-1:0] act, input logic [BD-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s got=%h exp=%h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        wr_en = '0;
        rd_en = '0;
    endtask

    task automatic wr(input int port, input int adr, input logic [BD-1:0] d);
        wr_en[port] = 1'b1; wr_adr[port] = BA'(adr); din[port] = d;
    endtask

    task automatic rd(input int port, input int adr);
        rd_en[port] = 1'b1; rd_adr[port] = BA'(adr);
    endtask

    initial begin
        logic [BD-1:0] r;
        for (int i = 0; i < NW; i++) begin wr_adr[i] = '0; din[i] = '0; end
        for (int i = 0; i < NR; i++) rd_adr[i] = '0;

        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("reset_dout0", dout[0], '0);
        chk("reset_dout1", dout[1], '0);

        tick();
        wr(0, 'h155, 45'h1234_5678); tick();
        idle(); rd(0, 'h155); tick();
        idle(); repeat (FO) tick();
        @(negedge clk);
        chk("basic_rd", dout[0], 45'h1234_5678);

        tick();
        wr(0, 'h3, 45'hA); tick();
        idle(); wr(0, 'h4, 45'hB); tick();
        idle(); rd(0, 'h3); rd(1, 'h4); tick();
        idle();
        @(negedge clk);
        chk("dual_rd0", dout[0], 45'hA);
        chk("dual_rd1", dout[1], 45'hB);

        tick();
        wr(0, 'h3, 45'hC);
        repeat (5) tick();
        idle();
        @(negedge clk);
        chk("hold_rd0", dout[0], 45'hA);
        chk("hold_rd1", dout[1], 45'hB);

        tick();
        wr(0, 'h10, 45'h1); tick();
        idle(); wr(0, 'h10, 45'h2); rd(0, 'h10); tick();
        idle(); rd(0, 'h10);
        @(negedge clk);
        chk("collide_old", dout[0], 45'h1);
        tick();
        idle();
        @(negedge clk);
        chk("collide_new", dout[0], 45'h2);

        tick();
        wr(0, 'h20, 45'h1_1111_1111); wr(1, 'h20, 45'h1F_2222_2222); tick();
        idle(); rd(1, 'h20); tick();
        idle();
        @(negedge clk);
        chk("wr_priority", dout[1], 45'h1F_2222_2222);

        tick();
        wr(0, 1000, 45'h1FFF_FFFF_FFFF); tick();
        idle(); rd(0, 1000); rd(1, 1023); tick();
        idle();
        @(negedge clk);
        chk("oor_rd1000", dout[0], '0);
        chk("oor_rd1023", dout[1], '0);

        for (int n = 0; n < 40; n++) begin
            int a;
            tick();
            idle();
            a = (n % 5 == 4) ? int'($urandom_range(1023, 990)) : int'($urandom_range(63, 0));
            r = {$urandom, $urandom};
            if (n % 2 == 0) r[44] = 1'b1;
            wr(0, a, r);
            if ($urandom_range(1, 0) == 1)
                wr(1, int'($urandom_range(63, 0)), {$urandom, $urandom});
            rd(1, int'($urandom_range(63, 0)));
            tick();
            idle();
            rd(0, a);
            if ($urandom_range(1, 0) == 1) rd(1, a);
        end
        tick();
        idle();
        repeat (3) tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_mem_sm_mem
`default_nettype wire
